// File: rtl/uart_frame_tx_if.sv
// Handshake bundle between the frame transmitter, its sample buffer and the UART byte transmitter.
// master = frame transmitter side, slave = buffer/UART/controller side.
interface uart_frame_tx_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              frame_busy;
  logic              frame_done;
  logic              error;
  logic [ADDR_W-1:0] rd_addr;
  logic [15:0]       rd_data;
  logic [7:0]        tx_data;
  logic              tx_enable;
  logic              tx_busy;

  modport master (
    input  start, rd_data, tx_busy,
    output frame_busy, frame_done, error, rd_addr, tx_data, tx_enable
  );

  modport slave (
    output start, rd_data, tx_busy,
    input  frame_busy, frame_done, error, rd_addr, tx_data, tx_enable
  );
endinterface

// File: rtl/uart_frame_tx.sv
// Frame transmitter: reads WORDS 16-bit samples and sends them over a byte UART as
// SYNC, LEN, low/high byte pairs and a mod-256 checksum, with a handshake timeout.
module uart_frame_tx #(
  parameter int         WORDS     = 64,
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 4096
) (
  input logic             clk,
  input logic             rst,
  uart_frame_tx_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, SYNC, LEN, FETCH, LO, HI, CSUM, DONE
  } state_t;

  localparam int         TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [7:0] LEN_BYTE = 8'(WORDS);
  localparam logic [7:0] LAST_IDX = 8'(WORDS - 1);

  state_t           state_reg, state_next;
  logic             busy_meta_reg, busy_sync_reg;
  logic             seen_busy_reg;
  logic [TMO_W-1:0] tmo_reg;
  logic [7:0]       idx_reg;
  logic [7:0]       csum_reg;
  logic [15:0]      word_reg;
  logic             fetch_cnt_reg;
  logic             error_reg;

  logic             accept;
  logic             byte_state;
  logic             byte_done;
  logic             timeout;
  logic             tx_en_c;
  logic [7:0]       tx_data_c;

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    byte_state = 1'b0;
    tx_data_c  = 8'h00;

    case (state_reg)
      SYNC:    begin byte_state = 1'b1; tx_data_c = SYNC_BYTE;      end
      LEN:     begin byte_state = 1'b1; tx_data_c = LEN_BYTE;       end
      LO:      begin byte_state = 1'b1; tx_data_c = word_reg[7:0];  end
      HI:      begin byte_state = 1'b1; tx_data_c = word_reg[15:8]; end
      CSUM:    begin byte_state = 1'b1; tx_data_c = csum_reg;       end
      default: ;
    endcase

    // Enable drops once busy has been seen; the byte completes when busy falls again.
    tx_en_c   = byte_state && !seen_busy_reg;
    byte_done = byte_state && seen_busy_reg && !busy_sync_reg;
    timeout   = tx_en_c && !busy_sync_reg && (tmo_reg == TMO_LAST);

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = SYNC;
        end
      end
      SYNC:  if (timeout) state_next = DONE; else if (byte_done) state_next = LEN;
      LEN:   if (timeout) state_next = DONE; else if (byte_done) state_next = FETCH;
      FETCH: if (fetch_cnt_reg) state_next = LO;
      LO:    if (timeout) state_next = DONE; else if (byte_done) state_next = HI;
      HI: begin
        if (timeout)
          state_next = DONE;
        else if (byte_done)
          state_next = (idx_reg < LAST_IDX) ? FETCH : CSUM;
      end
      CSUM:  if (timeout || byte_done) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      busy_meta_reg <= 1'b0;
      busy_sync_reg <= 1'b0;
      seen_busy_reg <= 1'b0;
      tmo_reg       <= '0;
      idx_reg       <= 8'h00;
      csum_reg      <= 8'h00;
      word_reg      <= 16'h0000;
      fetch_cnt_reg <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      busy_meta_reg <= bus.tx_busy;
      busy_sync_reg <= busy_meta_reg;

      if (accept || byte_done || timeout)
        seen_busy_reg <= 1'b0;
      else if (byte_state && busy_sync_reg)
        seen_busy_reg <= 1'b1;

      if (tx_en_c && !busy_sync_reg && !timeout)
        tmo_reg <= tmo_reg + 1'b1;
      else
        tmo_reg <= '0;

      if (accept)
        error_reg <= 1'b0;
      else if (timeout)
        error_reg <= 1'b1;

      // Checksum covers LEN and payload bytes, never SYNC or itself.
      if (accept)
        csum_reg <= 8'h00;
      else if (byte_done && (state_reg == LEN || state_reg == LO || state_reg == HI))
        csum_reg <= csum_reg + tx_data_c;

      if (accept)
        idx_reg <= 8'h00;
      else if (state_reg == HI && byte_done && !timeout && idx_reg < LAST_IDX)
        idx_reg <= idx_reg + 8'h01;

      fetch_cnt_reg <= (state_reg == FETCH) ? !fetch_cnt_reg : 1'b0;
      if (state_reg == FETCH && fetch_cnt_reg)
        word_reg <= bus.rd_data;
    end
  end

  assign bus.frame_busy = (state_reg != IDLE);
  assign bus.frame_done = (state_reg == DONE);
  assign bus.error      = error_reg;
  assign bus.rd_addr    = ADDR_W'(idx_reg);
  assign bus.tx_data    = tx_data_c;
  assign bus.tx_enable  = tx_en_c;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench: three frame transmitters (4-word, 1-word, 16-cycle timeout) with
// behavioural sample buffers and a 10-cycle-busy UART model capturing each sent byte.
module tb_uart_frame_tx;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_frame_tx_if #(.ADDR_W(8)) if4 ();
  uart_frame_tx_if #(.ADDR_W(8)) if1 ();
  uart_frame_tx_if #(.ADDR_W(8)) ift ();

  uart_frame_tx #(.WORDS(4), .ADDR_W(8), .SYNC_BYTE(8'hA5), .TIMEOUT(4096))
    dut4 (.clk(clk), .rst(rst), .bus(if4));
  uart_frame_tx #(.WORDS(1), .ADDR_W(8), .SYNC_BYTE(8'hA5), .TIMEOUT(4096))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  uart_frame_tx #(.WORDS(4), .ADDR_W(8), .SYNC_BYTE(8'hA5), .TIMEOUT(16))
    dutt (.clk(clk), .rst(rst), .bus(ift));

  logic [15:0] mem4 [0:3];
  initial begin
    mem4[0] = 16'h1234; mem4[1] = 16'hABCD; mem4[2] = 16'h0001; mem4[3] = 16'hFFFF;
  end

  always @(posedge clk) if4.rd_data <= mem4[if4.rd_addr[1:0]];
  always @(posedge clk) ift.rd_data <= mem4[ift.rd_addr[1:0]];
  always @(posedge clk) if1.rd_data <= 16'h0000;
  assign ift.tx_busy = 1'b0;

  byte_q_t q4, q1;
  int bcnt4 = 0, bcnt1 = 0;
  int done4 = 0, done1 = 0;

  // UART model: captures the byte on enable, stays busy for 10 cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      if4.tx_busy <= 1'b0; bcnt4 <= 0;
    end else if (bcnt4 != 0) begin
      bcnt4 <= bcnt4 - 1;
      if (bcnt4 == 1) if4.tx_busy <= 1'b0;
    end else if (if4.tx_enable && !if4.tx_busy) begin
      q4.push_back(if4.tx_data);
      if4.tx_busy <= 1'b1; bcnt4 <= 10;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      if1.tx_busy <= 1'b0; bcnt1 <= 0;
    end else if (bcnt1 != 0) begin
      bcnt1 <= bcnt1 - 1;
      if (bcnt1 == 1) if1.tx_busy <= 1'b0;
    end else if (if1.tx_enable && !if1.tx_busy) begin
      q1.push_back(if1.tx_data);
      if1.tx_busy <= 1'b1; bcnt1 <= 10;
    end
  end

  always @(posedge clk) if (if4.frame_done) done4++;
  always @(posedge clk) if (if1.frame_done) done1++;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bytes(input string tag, input byte_q_t got, input byte_q_t exp);
    check({tag, ".len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s.b%0d", tag, i), {24'h0, got[i]}, {24'h0, exp[i]});
    $display("frame %s: %0d bytes received", tag, got.size());
  endtask

  task automatic wait_done4(input int target, input string tag);
    int i;
    for (i = 0; i < 3000 && done4 < target; i++) @(negedge clk);
    check({tag, ".done_seen"}, (done4 >= target), 1);
  endtask

  task automatic wait_q4(input int n, input string tag);
    int i;
    for (i = 0; i < 3000 && q4.size() < n; i++) @(negedge clk);
    check({tag, ".reach"}, (q4.size() >= n), 1);
  endtask

  byte_q_t exp4, exp1, exp44;
  int base, n_en;

  initial begin
    exp4  = '{8'hA5, 8'h04, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h00, 8'hFF, 8'hFF, 8'hC1};
    exp1  = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h01};
    exp44 = {exp4, exp4};
    if4.start = 1'b0; if1.start = 1'b0; ift.start = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.frame_busy", if4.frame_busy, 0);
    check("rst.frame_done", if4.frame_done, 0);
    check("rst.tx_enable",  if4.tx_enable, 0);
    check("rst.tx_data",    if4.tx_data, 0);
    check("rst.rd_addr",    if4.rd_addr, 0);
    check("rst.error",      if4.error, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle.no_start", if4.frame_busy, 0);

    // Basic 4-word frame
    q4.delete(); base = done4;
    if4.start = 1'b1; @(negedge clk); if4.start = 1'b0;
    wait_done4(base + 1, "basic");
    check("basic.error", if4.error, 0);
    @(negedge clk);
    check("basic.done_pulse", if4.frame_done, 0);
    check("basic.idle", if4.frame_busy, 0);
    check("basic.done_count", done4 - base, 1);
    check_bytes("basic", q4, exp4);

    // Start during LO of word 2 is ignored
    q4.delete(); base = done4;
    if4.start = 1'b1; @(negedge clk); if4.start = 1'b0;
    wait_q4(7, "ign");
    if4.start = 1'b1; @(negedge clk); if4.start = 1'b0;
    wait_done4(base + 1, "ign");
    repeat (40) @(negedge clk);
    check("ign.not_queued", if4.frame_busy, 0);
    check("ign.done_count", done4 - base, 1);
    check_bytes("ign", q4, exp4);

    // Reset during HI of word 1
    q4.delete(); base = done4;
    if4.start = 1'b1; @(negedge clk); if4.start = 1'b0;
    wait_q4(6, "rstmid");
    rst = 1'b1; #1;
    check("rstmid.tx_enable", if4.tx_enable, 0);
    check("rstmid.frame_busy", if4.frame_busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid.no_done", done4 - base, 0);
    check("rstmid.stay_idle", if4.frame_busy, 0);
    q4.delete();
    if4.start = 1'b1; @(negedge clk); if4.start = 1'b0;
    wait_done4(base + 1, "rstmid");
    @(negedge clk);
    check_bytes("after_rst", q4, exp4);

    // Start held high: back-to-back frames with one idle cycle
    q4.delete(); base = done4;
    if4.start = 1'b1;
    for (int i = 0; i < 3000 && !if4.frame_done; i++) @(negedge clk);
    check("b2b.first_done", if4.frame_done, 1);
    @(negedge clk);
    check("b2b.gap_idle", if4.frame_busy, 0);
    @(negedge clk);
    check("b2b.restart_busy", if4.frame_busy, 1);
    check("b2b.restart_sync", if4.tx_data, 8'hA5);
    for (int i = 0; i < 3000 && !if4.frame_done; i++) @(negedge clk);
    check("b2b.second_done", if4.frame_done, 1);
    if4.start = 1'b0;
    repeat (5) @(negedge clk);
    check("b2b.stopped", if4.frame_busy, 0);
    check("b2b.done_count", done4 - base, 2);
    check_bytes("b2b", q4, exp44);

    // One-word frame
    q1.delete(); base = done1;
    if1.start = 1'b1; @(negedge clk); if1.start = 1'b0;
    for (int i = 0; i < 2000 && done1 == base; i++) @(negedge clk);
    check("w1.done_count", done1 - base, 1);
    check("w1.error", if1.error, 0);
    check_bytes("w1", q1, exp1);

    // Handshake timeout with tx_busy tied low
    ift.start = 1'b1; @(negedge clk); ift.start = 1'b0;
    n_en = 0;
    while (ift.tx_enable && n_en < 100) begin
      n_en++;
      @(negedge clk);
    end
    check("tmo.enable_cycles", n_en, 16);
    check("tmo.error", ift.error, 1);
    check("tmo.done_pulse", ift.frame_done, 1);
    @(negedge clk);
    check("tmo.idle", ift.frame_busy, 0);
    check("tmo.error_sticky", ift.error, 1);
    ift.start = 1'b1; @(negedge clk); ift.start = 1'b0;
    check("tmo.error_cleared", ift.error, 0);
    check("tmo.restart_busy", ift.frame_busy, 1);
    for (int i = 0; i < 100 && ift.frame_busy; i++) @(negedge clk);
    check("tmo.second_error", ift.error, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
